// File: rtl/hog_pkg.sv
// rtl/hog_pkg.sv - HOG feature word layout shared by the line-buffer slice
package hog_pkg;

  localparam int HOG_BIN_W = 4;
  localparam int HOG_MOD_W = 12;

  // Top and bottom half-pixels each carry an orientation bin and a gradient modulus.
  typedef struct packed {
    logic [HOG_BIN_W-1:0] top_bin;
    logic [HOG_MOD_W-1:0] top_mod;
    logic [HOG_BIN_W-1:0] bot_bin;
    logic [HOG_MOD_W-1:0] bot_mod;
  } hog_feature_t;

  localparam int HOG_FEATURE_W = $bits(hog_feature_t);

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one line of feature storage, simple dual-port, registered read-first
module line_ram
  import hog_pkg::*;
#(
  parameter int DEPTH = 1280,
  parameter int WIDTH = HOG_FEATURE_W,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             pclk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read and write share one process so a same-address write returns the old word.
  always_ff @(posedge pclk) begin
    if (re)
      rdata <= mem[raddr];
    if (we)
      mem[waddr] <= wdata;
  end

endmodule

// File: rtl/hog_line_buffer.sv
// rtl/hog_line_buffer.sv - multi-line delay buffer presenting vertically aligned HOG feature taps
module hog_line_buffer
  import hog_pkg::*;
#(
  parameter int IMAGE_WIDTH = 1280,
  parameter int DATA_WIDTH  = HOG_FEATURE_W,
  parameter int NUM_LINES   = 3
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic                          sof,
  input  logic                          de,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          deOut,
  output logic [NUM_LINES*DATA_WIDTH-1:0] taps,
  output logic                          primed,
  output logic                          line_error
);

  localparam int M  = NUM_LINES - 1;
  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int CW = $clog2(IMAGE_WIDTH + 1);
  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam int LW = $clog2(M + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMAGE_WIDTH);
  localparam logic [SW-1:0] SEL_LAST = SW'(M - 1);
  localparam logic [LW-1:0] CNT_MAX  = LW'(M);

  logic [CW-1:0] col, col_eff;
  logic [SW-1:0] wr_sel, sel_eff, sel1;
  logic [LW-1:0] line_cnt;
  logic          line_ovf, de_d1, line_end, pix_wr;
  logic          v1, ovf1;
  logic [DATA_WIDTH-1:0] d1;
  logic [AW-1:0] addr;
  logic [DATA_WIDTH-1:0] rd [M];
  logic [NUM_LINES*DATA_WIDTH-1:0] tap_next;

  // A pixel arriving with sof is column 0 of line 0, so it must see the cleared state now.
  assign col_eff  = sof ? '0 : col;
  assign sel_eff  = sof ? '0 : wr_sel;
  assign line_end = de_d1 && !de;
  assign pix_wr   = de && (col_eff < COL_MAX);
  assign addr     = col_eff[AW-1:0];
  assign primed   = (line_cnt == CNT_MAX) && !sof;

  for (genvar i = 0; i < M; i++) begin : g_ram
    line_ram #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (DATA_WIDTH)
    ) u_ram (
      .pclk  (pclk),
      .we    (pix_wr && (sel_eff == SW'(i))),
      .waddr (addr),
      .wdata (din),
      .re    (pix_wr),
      .raddr (addr),
      .rdata (rd[i])
    );
  end

  function automatic logic [SW-1:0] tap_slot(input logic [SW-1:0] sel, input int k);
    int s;
    s = int'(sel) - k;
    if (s < 0)
      s = s + M;
    return SW'(s);
  endfunction

  always_comb begin
    tap_next = '0;
    if (v1) begin
      tap_next[DATA_WIDTH-1:0] = d1;
      if (!ovf1)
        for (int k = 1; k < NUM_LINES; k++)
          tap_next[k*DATA_WIDTH +: DATA_WIDTH] = rd[tap_slot(sel1, k)];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      col        <= '0;
      wr_sel     <= '0;
      line_cnt   <= '0;
      line_ovf   <= 1'b0;
      de_d1      <= 1'b0;
      line_error <= 1'b0;
      v1         <= 1'b0;
      ovf1       <= 1'b0;
      d1         <= '0;
      sel1       <= '0;
      deOut      <= 1'b0;
      taps       <= '0;
    end else begin
      de_d1      <= de;
      // col saturates, so line_ovf remembers that the line ran past the last column.
      line_error <= line_end && !sof && ((col != COL_MAX) || line_ovf);
      if (sof) begin
        col      <= de ? CW'(1) : '0;
        wr_sel   <= '0;
        line_cnt <= '0;
        line_ovf <= 1'b0;
      end else if (line_end) begin
        col      <= '0;
        line_ovf <= 1'b0;
        wr_sel   <= (wr_sel == SEL_LAST) ? '0 : wr_sel + SW'(1);
        if (line_cnt != CNT_MAX)
          line_cnt <= line_cnt + LW'(1);
      end else if (de) begin
        if (col != COL_MAX)
          col <= col + CW'(1);
        else
          line_ovf <= 1'b1;
      end
      v1    <= de && primed;
      ovf1  <= !pix_wr;
      d1    <= din;
      sel1  <= sel_eff;
      deOut <= v1;
      taps  <= tap_next;
    end
  end

endmodule

// File: tb/tb_hog_line_buffer.sv
// tb/tb_hog_line_buffer.sv - bench for hog_line_buffer: line table, corner sequences, random lines
module tb_hog_line_buffer;

  localparam int IW = 8;
  localparam int NL = 3;
  localparam int DW = 32;
  localparam int M  = NL - 1;

  logic pclk = 1'b0;
  logic reset, sof, de;
  logic [DW-1:0] din;
  logic deOut, primed, line_error;
  logic [NL*DW-1:0] taps;

  always #5 pclk = ~pclk;

  hog_line_buffer #(
    .IMAGE_WIDTH (IW),
    .DATA_WIDTH  (DW),
    .NUM_LINES   (NL)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .sof        (sof),
    .de         (de),
    .din        (din),
    .deOut      (deOut),
    .taps       (taps),
    .primed     (primed),
    .line_error (line_error)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: M line memories addressed by frame line number mod M, expected values per cycle.
  logic [DW-1:0] mmem [M][IW];
  int mcol, mlen, mline, mcnt;
  bit mprev_de;
  logic [NL*DW-1:0] s1_taps, o_taps;
  bit s1_v, o_v, o_err;

  task automatic model_step();
    bit le, pin, v;
    int slot;
    logic [NL*DW-1:0] t;
    o_taps = s1_taps;
    o_v    = s1_v;
    if (reset) begin
      o_taps = '0; o_v = 0; o_err = 0; s1_taps = '0; s1_v = 0;
      mcol = 0; mlen = 0; mline = 0; mcnt = 0; mprev_de = 0;
      return;
    end
    pin   = (mcnt == M) && !sof;
    le    = mprev_de && !de;
    o_err = le && !sof && (mlen != IW);
    if (sof || le) begin mcol = 0; mlen = 0; end
    if (sof) begin mline = 0; mcnt = 0; end
    else if (le) begin mline++; if (mcnt < M) mcnt++; end
    v = de && pin;
    t = '0;
    if (de) begin
      mlen++;
      if (v) t[DW-1:0] = din;
      if (mcol < IW) begin
        for (int k = 1; k < NL; k++) begin
          slot = ((mline - k) % M + M) % M;
          if (v) t[k*DW +: DW] = mmem[slot][mcol];
        end
        mmem[mline % M][mcol] = din;
        mcol++;
      end
    end
    s1_taps  = t;
    s1_v     = v;
    mprev_de = de;
  endtask

  always @(posedge pclk) model_step();

  bit mon_en = 0;
  int err_cnt = 0, out_cnt = 0;
  bit got25 = 0;
  logic [NL*DW-1:0] taps25;

  always @(negedge pclk) begin
    if (mon_en) begin
      chk("deOut", {{(NL*DW-1){1'b0}}, deOut}, {{(NL*DW-1){1'b0}}, o_v});
      chk("taps", taps, o_taps);
      chk("primed", {{(NL*DW-1){1'b0}}, primed}, {{(NL*DW-1){1'b0}}, (mcnt == M) && !sof});
      chk("line_error", {{(NL*DW-1){1'b0}}, line_error}, {{(NL*DW-1){1'b0}}, o_err});
      if (line_error) err_cnt++;
      if (deOut) out_cnt++;
      if (deOut && taps[DW-1:0] == 32'h25 && !got25) begin
        got25  = 1;
        taps25 = taps;
      end
    end
  end

  int tline = 0;

  task automatic send_line(input int len, input int sof_at, input int gap, input bit rnd);
    for (int c = 0; c < len; c++) begin
      @(posedge pclk); #1;
      de  = 1'b1;
      din = rnd ? DW'($urandom) : DW'((tline % 16) * 16 + c);
      sof = (c == sof_at);
    end
    @(posedge pclk); #1;
    de = 1'b0; sof = 1'b0; din = '0;
    if (gap > 1) repeat (gap - 1) @(posedge pclk);
    tline++;
  endtask

  task automatic reset_mid(input int npix);
    for (int c = 0; c < npix; c++) begin
      @(posedge pclk); #1;
      de = 1'b1; din = DW'($urandom);
    end
    @(posedge pclk); #1;
    reset = 1'b1; de = 1'b0;
    @(posedge pclk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int len;
    bit sof_first;
    int exp_err;
    int exp_outs;
    bit exp_primed;
  } line_vec_t;

  line_vec_t vecs [16];

  initial begin
    vecs[0]  = '{8,  0, 0, 0, 0};
    vecs[1]  = '{8,  0, 0, 0, 1};
    for (int i = 2; i < 10; i++) vecs[i] = '{8, 0, 0, 8, 1};
    vecs[10] = '{6,  0, 1, 6, 1};
    vecs[11] = '{10, 0, 1, 10, 1};
    vecs[12] = '{8,  0, 0, 8, 1};
    vecs[13] = '{8,  1, 0, 0, 0};
    vecs[14] = '{8,  0, 0, 0, 1};
    vecs[15] = '{8,  0, 0, 8, 1};

    reset = 1'b1; sof = 1'b0; de = 1'b0; din = '0;
    repeat (2) @(posedge pclk);
    #1;
    mon_en = 1;
    @(negedge pclk);
    chk("reset_deOut", {{(NL*DW-1){1'b0}}, deOut}, '0);
    chk("reset_taps", taps, '0);
    chk("reset_primed", {{(NL*DW-1){1'b0}}, primed}, '0);
    chk("reset_line_error", {{(NL*DW-1){1'b0}}, line_error}, '0);
    @(posedge pclk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      err_cnt = 0; out_cnt = 0;
      send_line(vecs[i].len, vecs[i].sof_first ? 0 : -1, 1, 0);
      repeat (3) @(negedge pclk);
      chk($sformatf("line%0d_errors", i), NL*DW'(err_cnt), NL*DW'(vecs[i].exp_err));
      chk($sformatf("line%0d_outputs", i), NL*DW'(out_cnt), NL*DW'(vecs[i].exp_outs));
      chk($sformatf("line%0d_primed", i), {{(NL*DW-1){1'b0}}, primed}, {{(NL*DW-1){1'b0}}, vecs[i].exp_primed});
      @(posedge pclk); #1;
      if (i == 2) begin
        chk("prime_seen_col5", {{(NL*DW-1){1'b0}}, got25}, {{(NL*DW-1){1'b0}}, 1'b1});
        chk("prime_taps_col5", taps25, {32'h05, 32'h15, 32'h25});
      end
    end

    // Reset in the middle of a line, then re-prime over two full lines.
    repeat (3) send_line(IW, -1, 1, 0);
    reset_mid(4);
    @(negedge pclk);
    chk("rst_mid_deOut", {{(NL*DW-1){1'b0}}, deOut}, '0);
    chk("rst_mid_taps", taps, '0);
    chk("rst_mid_primed", {{(NL*DW-1){1'b0}}, primed}, '0);
    chk("rst_mid_line_error", {{(NL*DW-1){1'b0}}, line_error}, '0);
    send_line(IW, -1, 1, 0);
    repeat (3) @(negedge pclk);
    chk("reprime_after_1", {{(NL*DW-1){1'b0}}, primed}, '0);
    send_line(IW, -1, 1, 0);
    repeat (3) @(negedge pclk);
    chk("reprime_after_2", {{(NL*DW-1){1'b0}}, primed}, {{(NL*DW-1){1'b0}}, 1'b1});

    // Random lines: mostly full length, some short/long, sof at start or mid-line, rare reset.
    for (int n = 0; n < 200; n++) begin
      int len, sa, r;
      r   = $urandom_range(0, 99);
      len = (r < 70) ? IW : $urandom_range(IW - 3, IW + 3);
      sa  = -1;
      r   = $urandom_range(0, 99);
      if (r < 5) sa = 0;
      else if (r < 10) sa = $urandom_range(1, len - 1);
      else if (r < 13) reset_mid($urandom_range(1, IW - 1));
      send_line(len, sa, $urandom_range(1, 3), 1);
    end
    repeat (4) @(posedge pclk);
    @(negedge pclk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hog_line_buffer.md
# hog_line_buffer

Parametrised multi-line delay buffer for the car-detection HOG pipeline. It accepts one feature word per pixel, such as packed bins and moduli, while `de` is high. For every input pixel it presents that pixel together with the same-column pixels of the previous `NUM_LINES-1` lines as one vertically aligned tap vector. It sits between gradient/binning and the cell/block histogram stage. It generalises the single-line FIFO delay with multi-line taps, frame sync, priming status and line-length error detection.

## Interface
- `IMAGE_WIDTH`, 1280: active pixels per line; must be ≥ 2.
- `DATA_WIDTH`, 32: bits per pixel feature word.
- `NUM_LINES`, 3: taps per column, current line included; must be ≥ 2. `M = NUM_LINES-1` line memories.
- `pclk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sof`  in  1  start-of-frame pulse; clears line state.
- `de`  in  1  input pixel valid.
- `din`  in  DATA_WIDTH  input feature word.
- `deOut`  out  1  tap vector valid.
- `taps`  out  NUM_LINES*DATA_WIDTH  tap k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`; k=0 is the current line, k lines ago otherwise.
- `primed`  out  1  high once M complete lines have been stored since reset or `sof`.
- `line_error`  out  1  one-cycle pulse when a line length ≠ IMAGE_WIDTH.

## Operation
- Column counter `col`, range 0..IMAGE_WIDTH, increments on each `de` cycle and saturates at IMAGE_WIDTH.
- Line end is the falling edge of `de` (`de` was 1 last cycle, 0 now). At line end:
  - `col` is cleared.
  - `wr_sel` advances mod M.
  - `line_cnt` increments and saturates at M. `primed = (line_cnt == M)`.
  - If `col ≠ IMAGE_WIDTH`, `line_error` pulses; a line with IMAGE_WIDTH+1 or more pixels counts as ≠. The line still counts toward `line_cnt`.
- Per `de` pixel with `col < IMAGE_WIDTH`:
  - Every RAM is read at address `col`.
  - RAM `wr_sel` is written with `din`, read-first. The oldest line is therefore read before it is overwritten.
- Pixels with `col == IMAGE_WIDTH` (the overflow case) are not written. Their taps k≥1 are forced to 0.
- Tap mapping: tap k (k ≥ 1) comes from RAM `(wr_sel - k) mod M`. Tap 0 is `din`, delayed to align with the RAM reads.
- `deOut` is `de` delayed by 2 cycles, gated by the value of `primed` at input time.
- `taps` is all zero whenever `deOut = 0`.
- `sof`:
  - Clears `col`, `wr_sel`, `line_cnt` and `primed` in the same cycle.
  - If `de` is high in the same cycle, that pixel is column 0 of line 0 of the new frame.
  - No `line_error` is generated for a line truncated by `sof`.
- RAM contents are never cleared. `primed` gating guarantees no stale tap is emitted.

## Timing
- Reset values: `deOut = 0`, `taps = 0`, `primed = 0`, `line_error = 0`. Also cleared: `col`, `wr_sel`, `line_cnt` and the 2-stage pipeline.
- Latency: input at cycle t appears at the outputs at t+2.
  - Stage 1: RAM read and `din` register.
  - Stage 2: tap mux and output register.
- Throughput is one pixel per cycle. No backpressure is possible. A 1-cycle gap of `de` low is sufficient between lines.
- `line_error` is registered: it goes high in the cycle after line end is detected, for exactly one cycle.
- Reset mid-line: all outputs are 0 from the next cycle. The next line after reset is line 0.
- `primed` rises in the cycle after the M-th line end. The first pixel output with `deOut = 1` is pixel 0 of line M.

## Structure
- Package `hog_pkg`: the feature word layout fields (bin 4 b, modulus 12 b, top/bottom) and a `hog_feature_t` packed struct, with `DATA_WIDTH` defaulting to its `$bits`.
- Sub-module `line_ram`: simple dual-port RAM, parameters depth IMAGE_WIDTH and width DATA_WIDTH, one-cycle registered read, read-first on same-address write. It is instantiated M times in a generate loop and must infer block RAM.
- Counters, `wr_sel` rotation, line-end detection and the tap mux live in the top module.

## Test plan
- Priming, IMAGE_WIDTH=8, NUM_LINES=3, din = line*16 + col:
  - Lines 0–1 give `deOut = 0` throughout.
  - Line 2 col 5 gives taps {0x25, 0x15, 0x05} (tap 0 first) at t+2.
  - `primed` rises after line 1 ends.
- Steady state over 10 lines: every output satisfies tap k = din − k*16. `wr_sel` wraps correctly every 2 lines.
- Short line of 6 pixels: `line_error` pulses once, 1 cycle after `de` falls.
- Long line of 10 pixels: `line_error` pulses. Overflow pixels have taps 1..2 = 0. The following line's data is uncorrupted.
- `sof` after line 3, coincident with `de`: `primed` drops the same cycle; no output until new line 2; no `line_error`.
- `reset` asserted mid-line 4 for 1 cycle: all outputs 0 the next cycle; re-priming takes 2 full lines.
